ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Time-sliced arbiter sharing one synchronous RAM between a divided-clock CPU
// and a secondary requester that is only granted slots outside the CPU window.
module ram_arbiter #(
    parameter int DIV = 25,
    parameter int AW  = 13
) (
    input  logic          clk25,
    input  logic          rst_n,
    output logic          cpu_clken,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_we,
    input  logic [7:0]    dma_din,
    output logic          dma_ack,
    output logic [7:0]    dma_dout,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    localparam int SW = $clog2(DIV);
    localparam logic [SW-1:0] LAST = SW'(DIV - 1);
    localparam logic [SW-1:0] WIN  = SW'(DIV - 2);
    localparam logic [SW-1:0] GMAX = SW'(DIV - 4);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } dma_st_t;

    logic [SW-1:0] r_slot;
    dma_st_t       r_st;
    dma_st_t       w_st_nxt;
    logic          w_cpu_win;
    logic          w_we;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (r_slot == LAST) begin
            r_slot <= '0;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_st <= IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // A grant at slot DIV-4 or earlier keeps ISSUE clear of the CPU window.
    always_comb begin
        w_st_nxt = r_st;
        unique case (r_st)
            IDLE: begin
                if (dma_req && (r_slot <= GMAX)) begin
                    w_st_nxt = ISSUE;
                end
            end
            ISSUE:   w_st_nxt = ACK;
            ACK:     w_st_nxt = IDLE;
            default: w_st_nxt = IDLE;
        endcase
    end

    assign w_cpu_win = (r_slot >= WIN);

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        w_we     = 1'b0;
        if (w_cpu_win) begin
            w_we = (r_slot == LAST) & cpu_cs & cpu_we;
        end else if (r_st == ISSUE) begin
            ram_addr = dma_addr;
            ram_din  = dma_din;
            w_we     = dma_we;
        end
    end

    // Reset masks the strobe so an in-flight access never lands.
    assign ram_we    = w_we & rst_n;
    assign cpu_clken = (r_slot == LAST);
    assign cpu_dout  = ram_dout;
    assign dma_ack   = (r_st == ACK);
    assign dma_dout  = ram_dout;

endmodule
